// File: rtl/hamming_err_stat_pkg.sv
// Shared types for the hamming_err_* pipeline: data/parity words, error type
// and the event record queued by the statistics stage.
package hamming_err_stat_pkg;

    localparam int PAT_W     = 8;
    localparam int PAR_W     = 5;
    localparam int SEQ_MAX_W = 16;

    typedef logic [PAT_W-1:0] pattern_t;
    typedef logic [PAR_W-1:0] parity_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SEC  = 2'b01,
        ERR_DED  = 2'b10,
        ERR_ILL  = 2'b11
    } err_type_t;

    // seq is sized for the widest supported counter; narrower tops zero-extend.
    typedef struct packed {
        pattern_t               pattern;
        logic [SEQ_MAX_W-1:0]   seq;
        logic                   ill;
    } evt_t;

    function automatic logic is_uncorr(err_type_t e);
        return (e == ERR_DED) || (e == ERR_ILL);
    endfunction

endpackage

// File: rtl/hamming_err_stat_if.sv
// Beat input from hamming_err_dnc plus the valid/ready event drain port.
interface hamming_err_stat_if #(
    parameter int CNT_W = 16
);
    import hamming_err_stat_pkg::*;

    pattern_t           i_pattern;
    logic               i_valid;
    logic [1:0]         i_err_type;
    logic               o_evt_valid;
    logic               i_evt_ready;
    pattern_t           o_evt_pattern;
    logic [CNT_W-1:0]   o_evt_seq;
    logic               o_evt_ill;

    modport master (
        output i_pattern, i_valid, i_err_type, i_evt_ready,
        input  o_evt_valid, o_evt_pattern, o_evt_seq, o_evt_ill
    );

    modport slave (
        input  i_pattern, i_valid, i_err_type, i_evt_ready,
        output o_evt_valid, o_evt_pattern, o_evt_seq, o_evt_ill
    );

endinterface

// File: rtl/hamming_err_stat_evt_fifo.sv
// Synchronous register-array FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module stat_evt_fifo
    import hamming_err_stat_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = evt_t
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  T                        i_wdata,
    output T                        o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW:0]    rptr_q, rptr_d;
    logic           do_push, do_pop;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_count = wptr_q - rptr_q;
    assign o_rdata = mem_q[rptr_q[AW-1:0]];

    // A pop frees the head slot on the same edge, so a push into a full FIFO is legal then.
    assign do_pop  = i_pop & ~o_empty & ~i_clr;
    assign do_push = i_push & (~o_full | do_pop) & ~i_clr;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (i_clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/hamming_err_stat.sv
// Error statistics for the corrected Hamming stream: saturating word/SEC/DED
// counters, an uncorrectable-event FIFO with sticky drop flag, and an irq.
module hamming_err_stat
    import hamming_err_stat_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [CNT_W-1:0] SEC_THRESH = CNT_W'(8)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_clr,
    hamming_err_stat_if.slave   bus,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic [CNT_W-1:0]    o_sec_cnt,
    output logic [CNT_W-1:0]    o_ded_cnt,
    output logic                o_drop,
    output logic                o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   sec_cnt_q,  sec_cnt_d;
    logic [CNT_W-1:0]   ded_cnt_q,  ded_cnt_d;
    logic               drop_q, drop_d;
    logic               irq_q,  irq_d;

    err_type_t          err;
    logic               acc, push, pop;
    evt_t               evt_wr, evt_head;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic               unused_seq;

    assign err  = err_type_t'(bus.i_err_type);
    assign acc  = bus.i_valid & i_en & ~i_clr;
    assign push = acc & is_uncorr(err);
    assign pop  = bus.o_evt_valid & bus.i_evt_ready;

    assign evt_wr.pattern = bus.i_pattern;
    assign evt_wr.seq     = SEQ_MAX_W'(word_cnt_q);
    assign evt_wr.ill     = (err == ERR_ILL);

    stat_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata (evt_wr),
        .o_rdata (evt_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_cnt)
    );

    // Head fields read zero while empty so stale entries never leak out.
    assign bus.o_evt_valid   = ~fifo_empty;
    assign bus.o_evt_pattern = fifo_empty ? '0 : evt_head.pattern;
    assign bus.o_evt_seq     = fifo_empty ? '0 : evt_head.seq[CNT_W-1:0];
    assign bus.o_evt_ill     = fifo_empty ? 1'b0 : evt_head.ill;
    assign unused_seq        = ^evt_head.seq;

    always_comb begin
        word_cnt_d = word_cnt_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        drop_d     = drop_q;
        irq_d      = (sec_cnt_q >= SEC_THRESH) | (fifo_cnt != '0) | drop_q;
        if (i_clr) begin
            word_cnt_d = '0;
            sec_cnt_d  = '0;
            ded_cnt_d  = '0;
            drop_d     = 1'b0;
            irq_d      = 1'b0;
        end else if (acc) begin
            if (word_cnt_q != '1)                     word_cnt_d = word_cnt_q + 1'b1;
            if (err == ERR_SEC && sec_cnt_q != '1)    sec_cnt_d  = sec_cnt_q + 1'b1;
            if (is_uncorr(err) && ded_cnt_q != '1)    ded_cnt_d  = ded_cnt_q + 1'b1;
            if (push && fifo_full && !pop)            drop_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt_q <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            drop_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            drop_q     <= drop_d;
            irq_q      <= irq_d;
        end
    end

    assign o_word_cnt = word_cnt_q;
    assign o_sec_cnt  = sec_cnt_q;
    assign o_ded_cnt  = ded_cnt_q;
    assign o_drop     = drop_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_hamming_err_stat.sv
// Directed bench for hamming_err_stat: vector table plus hand sequences for
// threshold irq, FIFO overflow/drain, full push+pop, saturation and async reset.
module tb_hamming_err_stat;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en, clr;
    logic [CNT_W-1:0]   word_cnt, sec_cnt, ded_cnt;
    logic               drop, irq;
    int                 total = 0;
    int                 bad = 0;

    hamming_err_stat_if #(.CNT_W(CNT_W)) bus ();

    hamming_err_stat #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (4),
        .SEC_THRESH (8'd8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .bus        (bus),
        .o_word_cnt (word_cnt),
        .o_sec_cnt  (sec_cnt),
        .o_ded_cnt  (ded_cnt),
        .o_drop     (drop),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, valid;
        logic [1:0] et;
        logic [7:0] pat;
        logic       rdy;
        logic [7:0] w, s, d;
        logic       ev;
        logic [7:0] ep, es;
        logic       ei, dr, irq;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic e, input logic v, input logic [1:0] et,
                        input logic [7:0] pat, input logic rdy);
        en = e;
        bus.i_valid = v;
        bus.i_err_type = et;
        bus.i_pattern = pat;
        bus.i_evt_ready = rdy;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_evt_ready = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_pat [4];
        en = 1'b0; clr = 1'b0;
        bus.i_valid = 1'b0; bus.i_err_type = 2'b00;
        bus.i_pattern = '0; bus.i_evt_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word", word_cnt, 0);
        chk("rst_evt_valid", bus.o_evt_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_evt_pat", bus.o_evt_pattern, 0);
        rst_n = 1'b1;
        tick();

        // 10 NONE beats
        repeat (10) beat(1, 1, 2'b00, 8'h5A, 0);
        chk("none_word", word_cnt, 10);
        chk("none_sec", sec_cnt, 0);
        chk("none_ded", ded_cnt, 0);
        chk("none_evt_valid", bus.o_evt_valid, 0);
        chk("none_irq", irq, 0);

        // 8 SEC beats hit the threshold; irq one cycle after the count
        repeat (8) beat(1, 1, 2'b01, 8'h00, 0);
        chk("sec_cnt8", sec_cnt, 8);
        chk("sec_irq_lag", irq, 0);
        beat(1, 0, 2'b00, 8'h00, 0);
        chk("sec_irq", irq, 1);
        do_clr();
        chk("clr_word", word_cnt, 0);
        chk("clr_sec", sec_cnt, 0);
        chk("clr_irq", irq, 0);

        // 5 DED beats into a 4-deep FIFO: last one dropped
        for (int k = 1; k <= 5; k++) beat(1, 1, 2'b10, 8'(k * 8'h11), 0);
        chk("ovf_ded", ded_cnt, 5);
        chk("ovf_drop", drop, 1);
        bus.i_valid = 1'b0;
        bus.i_evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", bus.o_evt_valid, 1);
            chk("drain_pat", bus.o_evt_pattern, (k + 1) * 8'h11);
            chk("drain_seq", bus.o_evt_seq, k);
            tick();
        end
        chk("drain_empty", bus.o_evt_valid, 0);
        chk("drain_drop_sticky", drop, 1);
        do_clr();
        chk("clr_drop", drop, 0);

        // Full FIFO: push with simultaneous pop does not drop
        for (int k = 1; k <= 4; k++) beat(1, 1, 2'b10, 8'(8'h60 + k), 0);
        beat(1, 1, 2'b10, 8'h65, 1);
        chk("fullpp_drop", drop, 0);
        chk("fullpp_ded", ded_cnt, 5);
        bus.i_valid = 1'b0;
        bus.i_evt_ready = 1'b1;
        exp_pat = '{8'h62, 8'h63, 8'h64, 8'h65};
        for (int k = 0; k < 4; k++) begin
            chk("fullpp_valid", bus.o_evt_valid, 1);
            chk("fullpp_pat", bus.o_evt_pattern, exp_pat[k]);
            chk("fullpp_seq", bus.o_evt_seq, k + 1);
            tick();
        end
        chk("fullpp_empty", bus.o_evt_valid, 0);
        do_clr();

        // ILL/DED mix with i_en toggling
        //        en valid et    pat    rdy  w  s  d  ev ep     es ei dr irq
        tv[0] = '{1, 1, 2'b11, 8'hA1, 0,   1, 0, 1, 1, 8'hA1, 0, 1, 0, 0};
        tv[1] = '{0, 1, 2'b10, 8'hB2, 0,   1, 0, 1, 1, 8'hA1, 0, 1, 0, 1};
        tv[2] = '{1, 1, 2'b10, 8'hC3, 0,   2, 0, 2, 1, 8'hA1, 0, 1, 0, 1};
        tv[3] = '{0, 1, 2'b11, 8'hD4, 1,   2, 0, 2, 1, 8'hC3, 1, 0, 0, 1};
        tv[4] = '{0, 0, 2'b00, 8'h00, 1,   2, 0, 2, 0, 8'h00, 0, 0, 0, 1};
        tv[5] = '{1, 1, 2'b01, 8'h99, 0,   3, 1, 2, 0, 8'h00, 0, 0, 0, 0};
        tv[6] = '{1, 1, 2'b11, 8'hE5, 0,   4, 1, 3, 1, 8'hE5, 3, 1, 0, 0};
        tv[7] = '{1, 0, 2'b00, 8'h00, 1,   4, 1, 3, 0, 8'h00, 0, 0, 0, 1};
        foreach (tv[i]) begin
            beat(tv[i].en, tv[i].valid, tv[i].et, tv[i].pat, tv[i].rdy);
            chk($sformatf("tv%0d_word", i), word_cnt, tv[i].w);
            chk($sformatf("tv%0d_sec", i), sec_cnt, tv[i].s);
            chk($sformatf("tv%0d_ded", i), ded_cnt, tv[i].d);
            chk($sformatf("tv%0d_evt_valid", i), bus.o_evt_valid, tv[i].ev);
            chk($sformatf("tv%0d_evt_pat", i), bus.o_evt_pattern, tv[i].ep);
            chk($sformatf("tv%0d_evt_seq", i), bus.o_evt_seq, tv[i].es);
            chk($sformatf("tv%0d_evt_ill", i), bus.o_evt_ill, tv[i].ei);
            chk($sformatf("tv%0d_drop", i), drop, tv[i].dr);
            chk($sformatf("tv%0d_irq", i), irq, tv[i].irq);
        end
        do_clr();

        // Saturation: bring counters to all-ones minus 1, then 3 more SEC beats
        repeat (254) beat(1, 1, 2'b01, 8'h00, 0);
        chk("sat_pre_sec", sec_cnt, 8'hFE);
        chk("sat_pre_word", word_cnt, 8'hFE);
        for (int k = 0; k < 3; k++) begin
            beat(1, 1, 2'b01, 8'h00, 0);
            chk("sat_sec", sec_cnt, 8'hFF);
        end
        chk("sat_word", word_cnt, 8'hFF);
        beat(1, 1, 2'b10, 8'h77, 0);
        chk("sat_evt_seq", bus.o_evt_seq, 8'hFF);
        chk("sat_ded", ded_cnt, 1);
        chk("sat_irq", irq, 1);

        // Async reset between edges clears outputs immediately
        bus.i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", word_cnt, 0);
        chk("arst_sec", sec_cnt, 0);
        chk("arst_ded", ded_cnt, 0);
        chk("arst_evt_valid", bus.o_evt_valid, 0);
        chk("arst_evt_pat", bus.o_evt_pattern, 0);
        chk("arst_evt_seq", bus.o_evt_seq, 0);
        chk("arst_drop", drop, 0);
        chk("arst_irq", irq, 0);
        #3;
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
